// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter
//   Shares one memory port between the instruction-side and data-side
//   address-translation paths. Both page-table-walk reads and final accesses
//   from each side pass through here. Only one transaction is outstanding at
//   a time. A watchdog bounds how long a stalled memory transaction may wait.
//
//   Arbitration:
//     Default build            : round-robin; a tie goes to the side that did
//                                not win last time (D is "last" after reset).
//     ARB_DATA_PRIORITY_EN set : fixed priority; d_req wins every tie.
//
//   Handshakes:
//     i_req/d_req are level requests. The requester holds req and its fields
//     stable until it sees its 1-cycle ack pulse, and rdata is valid in that
//     same cycle. m_req is held high while a transaction waits on memory, and
//     m_* fields stay constant. m_ack is a 1-cycle completion pulse that
//     carries m_rdata. m_ack outside the wait phase is ignored.
//
//   Ports:
//     clk, rst                    clock, async active-high reset
//     i_req/i_addr -> i_ack/i_rdata                 instruction side (read only)
//     d_req/d_we/d_addr/d_wdata/d_wmask -> d_ack/d_rdata   data side
//     m_req/m_we/m_addr/m_wdata/m_wmask, m_rdata/m_ack     memory port
//     busy        transaction in progress
//     err         sticky watchdog-abort flag
//     dbg_state   current FSM state (0 idle, 1 wait, 2 resp)
module mmu_mem_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wmask,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state
);

  localparam int MASK_W = DATA_W / 8;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  // The counter holds the number of completed wait cycles. The last allowed
  // cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;            // 1 = data side
  logic                last_grant_q, last_grant_d;  // 1 = data side
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                m_we_q, m_we_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [MASK_W-1:0]   m_wmask_q, m_wmask_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;
  logic                grant_d_side;
  logic                wd_expire;

`ifdef ARB_DATA_PRIORITY_EN
  assign grant_d_side = d_req;
`else
  // Data side wins when it is alone, or on a tie when instruction went last.
  assign grant_d_side = d_req & (~i_req | ~last_grant_q);
`endif

  assign wd_expire = (wd_q == WD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_wmask_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_wmask_q    <= m_wmask_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_wmask_d    = m_wmask_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          owner_d = grant_d_side;
          wd_d    = '0;
          state_d = S_WAIT;
          if (grant_d_side) begin
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wmask_d = d_wmask;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
            m_wmask_d = '0;
          end
        end
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        // m_ack takes precedence, so a completion on the expiry cycle succeeds.
        if (m_ack) begin
          if (owner_q) d_rdata_d = m_rdata;
          else         i_rdata_d = m_rdata;
          state_d = S_RESP;
        end else if (wd_expire) begin
          if (owner_q) d_rdata_d = '0;
          else         i_rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. m_req is a function of the state register only, so reset
  // drops it immediately.
  always_comb begin
    busy  = (state_q != S_IDLE);
    m_req = (state_q == S_WAIT);
    i_ack = (state_q == S_RESP) & ~owner_q;
    d_ack = (state_q == S_RESP) & owner_q;
  end

  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wmask   = m_wmask_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mmu_mem_arbiter.sv
module tb_mmu_mem_arbiter;
  localparam int TO = 8;

  logic        clk, rst;
  logic        i_req;
  logic [63:0] i_addr;
  logic        i_ack;
  logic [63:0] i_rdata;
  logic        d_req, d_we;
  logic [63:0] d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        m_req, m_we;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  logic [63:0] m_rdata;
  logic        m_ack;
  logic        busy, err;
  logic [1:0]  dbg_state;

  mmu_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int mem_delay = -1;       // -1: memory never answers
  logic [63:0] mem_data = '0;
  logic manual_ack = 1'b0;  // one-shot m_ack pulse, independent of m_req
  int mreq_cnt = 0;
  logic ack_log[$];         // observed ack sides, 1 = data

  // transaction-level model state
  int          ph;          // 0 free, 1 memory outstanding, 2 reply cycle
  logic        own, last_d;
  int          waited;
  logic        e_we;
  logic [63:0] e_addr, e_wdata, e_irdata, e_drdata;
  logic [7:0]  e_mask;
  logic        e_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; own = 1'b0; last_d = 1'b1; waited = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0; e_mask = '0;
    e_irdata = '0; e_drdata = '0; e_err = 1'b0;
  endtask

  // Compare process: outputs checked on the falling edge, then the model
  // consumes the inputs the DUT will sample on the next rising edge.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (m_req) mreq_cnt++;
      if (i_ack) ack_log.push_back(1'b0);
      if (d_ack) ack_log.push_back(1'b1);
      if (rst) begin
        model_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_acks", 64'({i_ack, d_ack}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", i_rdata | d_rdata, 64'd0);
        chk("rst_m_fields", m_addr | m_wdata | 64'(m_wmask) | 64'(m_we), 64'd0);
      end else begin
        chk("busy", 64'(busy), 64'(ph != 0));
        chk("state_vs_busy", 64'(dbg_state != 2'd0), 64'(ph != 0));
        chk("m_req", 64'(m_req), 64'(ph == 1));
        chk("i_ack", 64'(i_ack), 64'(ph == 2 && !own));
        chk("d_ack", 64'(d_ack), 64'(ph == 2 && own));
        chk("i_rdata", i_rdata, e_irdata);
        chk("d_rdata", d_rdata, e_drdata);
        chk("err", 64'(err), 64'(e_err));
        if (ph == 1) begin
          chk("m_we", 64'(m_we), 64'(e_we));
          chk("m_addr", m_addr, e_addr);
          chk("m_wdata", m_wdata, e_wdata);
          chk("m_wmask", 64'(m_wmask), 64'(e_mask));
        end
        case (ph)
          0: if (i_req || d_req) begin
               if (i_req && d_req) begin
`ifdef ARB_DATA_PRIORITY_EN
                 own = 1'b1;
`else
                 own = !last_d;
`endif
               end else begin
                 own = d_req;
               end
               if (own) begin
                 e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_mask = d_wmask;
               end else begin
                 e_we = 1'b0; e_addr = i_addr; e_wdata = '0; e_mask = '0;
               end
               waited = 0;
               ph = 1;
             end
          1: begin
               waited++;
               if (m_ack) begin
                 if (own) e_drdata = m_rdata; else e_irdata = m_rdata;
                 ph = 2;
               end else if (waited == TO) begin
                 if (own) e_drdata = '0; else e_irdata = '0;
                 e_err = 1'b1;
                 ph = 2;
               end
             end
          default: begin
               last_d = own;
               ph = 0;
             end
        endcase
      end
    end
  endtask

  // Memory responder: answers mem_delay cycles after m_req is first seen.
  task automatic responder();
    int ctr = 0;
    forever begin
      @(posedge clk); #1;
      m_ack = 1'b0;
      if (manual_ack) begin
        m_ack = 1'b1; m_rdata = mem_data; manual_ack = 1'b0; ctr = 0;
      end else if (m_req && mem_delay >= 0) begin
        if (ctr == mem_delay) begin
          m_ack = 1'b1; m_rdata = mem_data; ctr = 0;
        end else begin
          ctr++;
        end
      end else begin
        ctr = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic i_txn(input logic [63:0] addr, output int lat);
    int n = 0;
    i_req = 1'b1; i_addr = addr;
    do begin @(posedge clk); #1; n++; end while (!i_ack && n < 200);
    chk("i_ack_seen", 64'(i_ack), 64'd1);
    i_req = 1'b0;
    lat = n;
  endtask

  task automatic d_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] mask, output int lat);
    int n = 0;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_wmask = mask;
    do begin @(posedge clk); #1; n++; end while (!d_ack && n < 200);
    chk("d_ack_seen", 64'(d_ack), 64'd1);
    d_req = 1'b0;
    lat = n;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;
    logic exp_order[6];
    rst = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    m_ack = 1'b0; m_rdata = '0;
    model_reset();
    fork
      compare_loop();
      responder();
    join_none
    do_reset();
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // 1: instruction read, memory answers 3 cycles after m_req
    mem_delay = 3; mem_data = 64'hDEAD;
    i_txn(64'h8000_1000, lat);
    chk("t1_latency", 64'(lat), 64'd5);
    chk("t1_i_rdata", i_rdata, 64'hDEAD);
    chk("t1_m_addr", m_addr, 64'h8000_1000);
    chk("t1_m_we", 64'(m_we), 64'd0);

    // 2: data write, one ack on the data side only
    @(posedge clk); #1;
    ack_log.delete();
    mem_delay = 1; mem_data = 64'h77;
    d_txn(1'b1, 64'h8020_0008, 64'h1234, 8'h0F, lat);
    chk("t2_latency", 64'(lat), 64'd3);
    chk("t2_m_we", 64'(m_we), 64'd1);
    chk("t2_m_addr", m_addr, 64'h8020_0008);
    chk("t2_m_wdata", m_wdata, 64'h1234);
    chk("t2_m_wmask", 64'(m_wmask), 64'h0F);
    chk("t2_i_rdata_kept", i_rdata, 64'hDEAD);
    @(posedge clk); #1;
    chk("t2_ack_count", 64'(ack_log.size()), 64'd1);
    if (ack_log.size() == 1) chk("t2_ack_side", 64'(ack_log[0]), 64'd1);

    // 6: spurious m_ack in idle, then zero-wait completion
    #1 mem_data = 64'h5555; manual_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_idle_busy", 64'(busy), 64'd0);
      chk("t6_idle_acks", 64'({i_ack, d_ack}), 64'd0);
    end
    chk("t6_i_rdata_kept", i_rdata, 64'hDEAD);
    mem_delay = 0; mem_data = 64'hBEEF;
    i_txn(64'h8000_2000, lat);
    chk("t6_zero_wait_latency", 64'(lat), 64'd2);
    chk("t6_i_rdata", i_rdata, 64'hBEEF);

    // 3: contention after reset, both sides keep requesting
    do_reset();
    ack_log.delete();
    mem_delay = 1; mem_data = 64'hA5A5;
`ifdef ARB_DATA_PRIORITY_EN
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    fork
      begin
        int l;
        for (int k = 0; k < 3; k++) i_txn(64'h8000_4000 + 64'(k * 8), l);
      end
      begin
        int l;
        for (int k = 0; k < 3; k++) d_txn(1'b0, 64'h8030_0000 + 64'(k * 8), '0, '0, l);
      end
    join
    @(posedge clk); #1;
    chk("t3_ack_count", 64'(ack_log.size()), 64'd6);
    n = (ack_log.size() < 6) ? ack_log.size() : 6;
    for (int k = 0; k < n; k++) chk("t3_grant_order", 64'(ack_log[k]), 64'(exp_order[k]));

    // 4: memory never answers -> watchdog abort
    @(posedge clk); #1;
    mem_delay = -1; mreq_cnt = 0;
    i_txn(64'h8000_3000, lat);
    chk("t4_latency", 64'(lat), 64'd9);
    chk("t4_i_rdata_zero", i_rdata, 64'd0);
    chk("t4_err", 64'(err), 64'd1);
    @(posedge clk); #1;
    chk("t4_mreq_cycles", 64'(mreq_cnt), 64'(TO));
    mem_delay = 2; mem_data = 64'hC0FFEE;
    d_txn(1'b0, 64'h8040_0010, '0, '0, lat);
    chk("t4_err_sticky", 64'(err), 64'd1);
    chk("t4_d_rdata", d_rdata, 64'hC0FFEE);

    // 5: reset while waiting on memory, then a late m_ack
    @(posedge clk); #1;
    mem_delay = -1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8050_0000; d_wdata = 64'h99; d_wmask = 8'hFF;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!m_req && n < 20);
    chk("t5_in_wait", 64'(m_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_async_m_req", 64'(m_req), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    chk("t5_async_err", 64'(err), 64'd0);
    d_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0; mem_data = 64'hBAD; manual_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("t5_no_ack", 64'({i_ack, d_ack}), 64'd0);
      chk("t5_idle", 64'(busy), 64'd0);
    end
    chk("t5_d_rdata", d_rdata, 64'd0);

    // normal operation after the abort
    mem_delay = 0; mem_data = 64'h1111;
    i_txn(64'h8000_5000, lat);
    chk("post_latency", 64'(lat), 64'd2);
    chk("post_i_rdata", i_rdata, 64'h1111);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
